// File: rtl/rr_pkg.sv
// Shared types and defaults for the round-robin scheduler and its slice executor.
package rr_pkg;

  localparam int RR_QUANTUM  = 3;
  localparam int RR_NUM_PROC = 5;
  localparam int RR_BURST_W  = 8;

  function automatic int rr_pid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RR_PID_W = rr_pid_w(RR_NUM_PROC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REQ  = 2'd2
  } rr_state_e;

  // Slice descriptor exchanged with the scheduler at the default widths.
  typedef struct packed {
    logic [RR_PID_W-1:0]   pid;
    logic [RR_BURST_W-1:0] burst;
  } rr_slice_t;

endpackage

// File: rtl/rr_slice_executor_if.sv
// Dispatch (scheduler -> executor) and requeue (executor -> scheduler) handshakes.
interface rr_slice_executor_if
  import rr_pkg::*;
#(
  parameter int PID_W   = RR_PID_W,
  parameter int BURST_W = RR_BURST_W
);
  logic               disp_valid;
  logic               disp_ready;
  logic [PID_W-1:0]   disp_pid;
  logic [BURST_W-1:0] disp_burst;
  logic               rq_valid;
  logic               rq_ready;
  logic [PID_W-1:0]   rq_pid;
  logic [BURST_W-1:0] rq_burst;

  modport master (
    output disp_valid, disp_pid, disp_burst, rq_ready,
    input  disp_ready, rq_valid, rq_pid, rq_burst
  );

  modport slave (
    input  disp_valid, disp_pid, disp_burst, rq_ready,
    output disp_ready, rq_valid, rq_pid, rq_burst
  );
endinterface

// File: rtl/rr_slice_timer.sv
// Loadable down-counter; o_last flags the final cycle of a slice (count == 1).
module rr_slice_timer #(
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [BURST_W-1:0] i_load_val,
  output logic               o_last
);
  logic [BURST_W-1:0] r_count;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == BURST_W'(1));
endmodule

// File: rtl/rr_slice_executor.sv
// Runs one min(QUANTUM, burst) slice per dispatch, then retires or requeues the process.
// Optional RR_EXEC_STATS_EN adds saturating run_cycles / slice_count counters.
module rr_slice_executor
  import rr_pkg::*;
#(
  parameter int  QUANTUM  = RR_QUANTUM,
  parameter int  NUM_PROC = RR_NUM_PROC,
  parameter int  BURST_W  = RR_BURST_W,
  localparam int PID_W    = rr_pid_w(NUM_PROC)
) (
  input  logic                clk,
  input  logic                rst,
  rr_slice_executor_if.slave  bus,
  output logic                busy,
  output logic [PID_W-1:0]    run_pid,
  output logic [NUM_PROC-1:0] done_mask,
  output logic                all_done
`ifdef RR_EXEC_STATS_EN
  ,
  output logic [31:0]         run_cycles,
  output logic [15:0]         slice_count
`endif
);
  localparam logic [BURST_W-1:0] Q_B = BURST_W'(QUANTUM);

  rr_state_e           r_state, w_next;
  logic [PID_W-1:0]    r_pid;
  logic [BURST_W-1:0]  r_burst, r_rq_burst, w_slice_len;
  logic [NUM_PROC-1:0] r_done, w_set;
  logic w_disp_ready, w_rq_valid, w_busy;
  logic w_accept, w_pid_ok, w_start, w_zero_done;
  logic w_last, w_run_end, w_run_done, w_to_req;

  assign w_accept    = bus.disp_valid && w_disp_ready;
  assign w_pid_ok    = {1'b0, bus.disp_pid} < (PID_W+1)'(NUM_PROC);
  assign w_start     = w_accept && w_pid_ok && (bus.disp_burst != '0);
  assign w_zero_done = w_accept && w_pid_ok && (bus.disp_burst == '0);
  assign w_slice_len = (bus.disp_burst < Q_B) ? bus.disp_burst : Q_B;

  assign w_run_end  = (r_state == RUN) && w_last;
  assign w_run_done = w_run_end && (r_burst <= Q_B);
  assign w_to_req   = w_run_end && (r_burst > Q_B);
  assign w_set      = ({NUM_PROC{w_zero_done}} & (NUM_PROC'(1) << bus.disp_pid))
                    | ({NUM_PROC{w_run_done}}  & (NUM_PROC'(1) << r_pid));

  rr_slice_timer #(.BURST_W(BURST_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_load_val (w_slice_len),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: defaults first, so no branch of the case can leave a latch behind.
  always_comb begin
    w_next       = r_state;
    w_disp_ready = 1'b0;
    w_rq_valid   = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_disp_ready = !rst;
        if (w_start) w_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_run_done)    w_next = IDLE;
        else if (w_to_req) w_next = REQ;
      end
      REQ: begin
        w_rq_valid = 1'b1;
        if (bus.rq_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pid      <= '0;
      r_burst    <= '0;
      r_rq_burst <= '0;
      r_done     <= '0;
    end else begin
      if (w_start) begin
        r_pid   <= bus.disp_pid;
        r_burst <= bus.disp_burst;
      end
      // Subtraction only happens when burst > QUANTUM, so it cannot wrap.
      if (w_to_req) r_rq_burst <= r_burst - Q_B;
      r_done <= r_done | w_set;
    end
  end

`ifdef RR_EXEC_STATS_EN
  logic [31:0] r_run_cycles;
  logic [15:0] r_slice_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cycles  <= '0;
      r_slice_count <= '0;
    end else begin
      if (r_state == RUN && r_run_cycles != '1) r_run_cycles <= r_run_cycles + 1'b1;
      if (w_start && r_slice_count != '1)       r_slice_count <= r_slice_count + 1'b1;
    end
  end

  assign run_cycles  = r_run_cycles;
  assign slice_count = r_slice_count;
`endif

  assign bus.disp_ready = w_disp_ready;
  assign bus.rq_valid   = w_rq_valid;
  assign bus.rq_pid     = r_pid;
  assign bus.rq_burst   = r_rq_burst;
  assign busy           = w_busy;
  assign run_pid        = r_pid;
  assign done_mask      = r_done;
  assign all_done       = &r_done;
endmodule

// File: tb/tb_rr_slice_executor.sv
// Self-checking bench for rr_slice_executor: vector table, FIFO round-robin loop, corner sequences, random slices.
module tb_rr_slice_executor;
  import rr_pkg::*;

  localparam int Q  = 3;
  localparam int NP = 5;

  logic       clk, rst;
  logic       busy, all_done;
  logic [2:0] run_pid;
  logic [4:0] done_mask;
`ifdef RR_EXEC_STATS_EN
  logic [31:0] run_cycles;
  logic [15:0] slice_count;
`endif

  rr_slice_executor_if #(.PID_W(3), .BURST_W(8)) bus ();

  rr_slice_executor #(.QUANTUM(Q), .NUM_PROC(NP), .BURST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .run_pid   (run_pid),
    .done_mask (done_mask),
    .all_done  (all_done)
`ifdef RR_EXEC_STATS_EN
    ,
    .run_cycles  (run_cycles),
    .slice_count (slice_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.disp_valid = 1'b0; bus.disp_pid = '0; bus.disp_burst = '0; bus.rq_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_disp_ready"}, bus.disp_ready, 0);
    check({tag, "_rq_valid"},   bus.rq_valid, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_run_pid"},    run_pid, 0);
    check({tag, "_rq_pid"},     bus.rq_pid, 0);
    check({tag, "_rq_burst"},   bus.rq_burst, 0);
    check({tag, "_done_mask"},  done_mask, 0);
    check({tag, "_all_done"},   all_done, 0);
  endtask

  // Offer one slice, follow it to completion, answering a requeue after 'delay' cycles.
  task automatic run_slice(input logic [2:0] pid, input logic [7:0] burst, input int delay,
                           output int nbusy, output bit rq_seen, output logic [2:0] rpid,
                           output logic [7:0] rburst, output int hold);
    bit fin;
    nbusy = 0; rq_seen = 0; rpid = '0; rburst = '0; hold = 0; fin = 0;
    @(negedge clk);
    check("disp_ready_idle", bus.disp_ready, 1);
    bus.disp_valid = 1'b1; bus.disp_pid = pid; bus.disp_burst = burst;
    @(posedge clk); #1;
    bus.disp_valid = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (bus.rq_valid) begin
        if (!rq_seen) begin
          rq_seen = 1; rpid = bus.rq_pid; rburst = bus.rq_burst;
          check("rq_rise_cycle", c, nbusy);
        end else begin
          check("rq_pid_stable",   bus.rq_pid, rpid);
          check("rq_burst_stable", bus.rq_burst, rburst);
          check("disp_ready_req",  bus.disp_ready, 0);
        end
        if (hold >= delay) begin
          bus.rq_ready = 1'b1;
          @(posedge clk); #1;
          bus.rq_ready = 1'b0;
          fin = 1;
        end else hold++;
      end else if (busy) begin
        if (nbusy == 0) check("busy_start_cycle", c, 0);
        check("run_pid", run_pid, pid);
        check("disp_ready_run", bus.disp_ready, 0);
        nbusy++;
      end else if (bus.disp_ready) fin = 1;
    end
    if (!fin) check("slice_timeout", 0, 1);
  endtask

  typedef struct {
    logic [2:0] pid;
    logic [7:0] burst;
    int         exp_busy;
    bit         exp_rq;
    logic [7:0] exp_rburst;
    logic [4:0] exp_mask;
    bit         exp_all;
  } vec_t;

  vec_t       vec [9];
  rr_slice_t  q [$];
  rr_slice_t  cur;
  logic [4:0] m_mask;
  int         nb, hold, busy_sum, flag;
  bit         rq;
  logic [2:0] rp, pid;
  logic [7:0] rb, burst;

  initial begin
    vec[0] = '{3'd0, 8'd8,   3, 1'b1, 8'd5,   5'b00000, 1'b0};
    vec[1] = '{3'd3, 8'd3,   3, 1'b0, 8'd0,   5'b01000, 1'b0};
    vec[2] = '{3'd4, 8'd2,   2, 1'b0, 8'd0,   5'b11000, 1'b0};
    vec[3] = '{3'd1, 8'd0,   0, 1'b0, 8'd0,   5'b11010, 1'b0};
    vec[4] = '{3'd7, 8'd5,   0, 1'b0, 8'd0,   5'b11010, 1'b0};
    vec[5] = '{3'd2, 8'd1,   1, 1'b0, 8'd0,   5'b11110, 1'b0};
    vec[6] = '{3'd3, 8'd4,   3, 1'b1, 8'd1,   5'b11110, 1'b0};
    vec[7] = '{3'd0, 8'd255, 3, 1'b1, 8'd252, 5'b11110, 1'b0};
    vec[8] = '{3'd0, 8'd2,   2, 1'b0, 8'd0,   5'b11111, 1'b1};

    // Reset state, sampled while rst is held.
    rst = 1'b1;
    bus.disp_valid = 1'b0; bus.disp_pid = '0; bus.disp_burst = '0; bus.rq_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Table-driven single slices.
    for (int i = 0; i < 9; i++) begin
      run_slice(vec[i].pid, vec[i].burst, 0, nb, rq, rp, rb, hold);
      check($sformatf("vec%0d_busy_cycles", i), nb, vec[i].exp_busy);
      check($sformatf("vec%0d_requeue", i), rq, vec[i].exp_rq);
      if (vec[i].exp_rq) begin
        check($sformatf("vec%0d_rq_pid", i), rp, vec[i].pid);
        check($sformatf("vec%0d_rq_burst", i), rb, vec[i].exp_rburst);
      end
      check($sformatf("vec%0d_done_mask", i), done_mask, vec[i].exp_mask);
      check($sformatf("vec%0d_all_done", i), all_done, vec[i].exp_all);
    end

    // Requeue held off for 10 cycles.
    run_slice(3'd2, 8'd7, 10, nb, rq, rp, rb, hold);
    check("hold_requeue", rq, 1);
    check("hold_cycles", hold, 10);
    check("hold_rq_pid", rp, 2);
    check("hold_rq_burst", rb, 4);

    // Full round-robin loop: the model FIFO feeds every requeue back to the tail.
    apply_reset();
    q.delete();
    q.push_back('{pid: 3'd0, burst: 8'd8});
    q.push_back('{pid: 3'd1, burst: 8'd9});
    q.push_back('{pid: 3'd2, burst: 8'd11});
    q.push_back('{pid: 3'd3, burst: 8'd5});
    q.push_back('{pid: 3'd4, burst: 8'd4});
    m_mask = '0; busy_sum = 0;
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      cur = q.pop_front();
      run_slice(cur.pid, cur.burst, 0, nb, rq, rp, rb, hold);
      busy_sum += nb;
      check("loop_busy", nb, (cur.burst < 8'(Q)) ? int'(cur.burst) : Q);
      check("loop_requeue", rq, cur.burst > 8'(Q));
      if (cur.burst > 8'(Q)) begin
        check("loop_rq_pid", rp, cur.pid);
        check("loop_rq_burst", rb, cur.burst - 8'(Q));
        q.push_back('{pid: cur.pid, burst: cur.burst - 8'(Q)});
      end else m_mask[cur.pid] = 1'b1;
      check("loop_done_mask", done_mask, m_mask);
      check("loop_all_done", all_done, &m_mask);
    end
    check("loop_total_busy", busy_sum, 37);
    check("loop_queue_drained", q.size(), 0);

    // Reset two cycles into a burst-9 slice.
    apply_reset();
    @(negedge clk);
    bus.disp_valid = 1'b1; bus.disp_pid = 3'd1; bus.disp_burst = 8'd9;
    @(posedge clk); #1;
    bus.disp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_values("midrun");
    @(negedge clk);
    rst = 1'b0;
    flag = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rq_valid || busy || done_mask != 0) flag = 1;
    end
    check("post_reset_quiet", flag, 0);
    run_slice(3'd7, 8'd5, 0, nb, rq, rp, rb, hold);
    check("bad_pid_busy", nb, 0);
    check("bad_pid_requeue", rq, 0);
    check("bad_pid_mask", done_mask, 0);

    // Random slices against the spec model: slice length, requeue and sticky done bits.
    apply_reset();
    m_mask = '0;
    for (int n = 0; n < 40; n++) begin
      pid   = 3'($urandom_range(0, 7));
      burst = 8'($urandom_range(0, 12));
      run_slice(pid, burst, int'($urandom_range(0, 3)), nb, rq, rp, rb, hold);
      if (pid < 3'(NP)) begin
        check("rand_busy", nb, (burst < 8'(Q)) ? int'(burst) : Q);
        check("rand_requeue", rq, burst > 8'(Q));
        if (burst > 8'(Q)) begin
          check("rand_rq_pid", rp, pid);
          check("rand_rq_burst", rb, burst - 8'(Q));
        end else m_mask[pid] = 1'b1;
      end else begin
        check("rand_badpid_busy", nb, 0);
        check("rand_badpid_requeue", rq, 0);
      end
      check("rand_done_mask", done_mask, m_mask);
      check("rand_all_done", all_done, &m_mask);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
